// File: rtl/encoder_4to2_if.sv
// Request/result bundle between a request source and the 4-to-2 priority encoder.
interface encoder_4to2_if;
    logic en;
    logic d0;
    logic d1;
    logic d2;
    logic d3;
    logic a;
    logic b;
    logic valid;
    logic multi;
    logic chg;

    // Request source: drives enable and request lines, observes the encoded result.
    modport master (
        output en,
        output d0,
        output d1,
        output d2,
        output d3,
        input  a,
        input  b,
        input  valid,
        input  multi,
        input  chg
    );

    // Encoder: samples enable and request lines, drives the registered result.
    modport slave (
        input  en,
        input  d0,
        input  d1,
        input  d2,
        input  d3,
        output a,
        output b,
        output valid,
        output multi,
        output chg
    );
endinterface

// File: rtl/encoder_4to2.sv
// Registered 4-to-2 priority encoder with any-active, multiple-active and
// code-change indications. HIGH_PRIO selects whether d3 or d0 wins.
module encoder_4to2 #(
    parameter bit HIGH_PRIO = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    encoder_4to2_if.slave bus
);

    localparam int unsigned CODE_W = 2;
    localparam int unsigned CNT_W  = 3;

    logic [CODE_W-1:0] code_c;
    logic              valid_c;
    logic              multi_c;
    logic [CNT_W-1:0]  count_c;

    // Priority selection of the winning request line; no request encodes as 00.
    always_comb begin
        code_c = 2'b00;
        if (HIGH_PRIO) begin
            if (bus.d3) begin
                code_c = 2'b11;
            end else if (bus.d2) begin
                code_c = 2'b10;
            end else if (bus.d1) begin
                code_c = 2'b01;
            end
        end else begin
            if (bus.d0) begin
                code_c = 2'b00;
            end else if (bus.d1) begin
                code_c = 2'b01;
            end else if (bus.d2) begin
                code_c = 2'b10;
            end else if (bus.d3) begin
                code_c = 2'b11;
            end
        end
    end

    // Activity flags: any request, and two or more simultaneous requests.
    always_comb begin
        count_c = CNT_W'(bus.d0) + CNT_W'(bus.d1) + CNT_W'(bus.d2) + CNT_W'(bus.d3);
        valid_c = (count_c != 3'd0);
        multi_c = (count_c >= 3'd2);
    end

    // Result registers; hold on en=0, chg pulses only when a sampled code differs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.a     <= 1'b0;
            bus.b     <= 1'b0;
            bus.valid <= 1'b0;
            bus.multi <= 1'b0;
            bus.chg   <= 1'b0;
        end else if (bus.en) begin
            bus.a     <= code_c[1];
            bus.b     <= code_c[0];
            bus.valid <= valid_c;
            bus.multi <= multi_c;
            bus.chg   <= (code_c != {bus.a, bus.b});
        end else begin
            bus.chg   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_encoder_4to2.sv
// Self-checking bench: runs both priority orders side by side against a
// behavioural model of the encoder.
module tb_encoder_4to2;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    encoder_4to2_if bus_lo ();
    encoder_4to2_if bus_hi ();

    encoder_4to2 #(.HIGH_PRIO(1'b0)) dut_lo (.clk(clk), .rst(rst), .bus(bus_lo));
    encoder_4to2 #(.HIGH_PRIO(1'b1)) dut_hi (.clk(clk), .rst(rst), .bus(bus_hi));

    always #5 clk = ~clk;

    // Model state, index 0 = low-index priority, 1 = high-index priority.
    logic [1:0] m_code  [2];
    logic       m_valid [2];
    logic       m_multi [2];
    logic       m_chg   [2];

    logic       cur_en;
    logic [3:0] cur_d;

    // Winning line index by scanning the request vector in priority order.
    function automatic logic [1:0] winner(input logic [3:0] d, input bit hp);
        if (hp) begin
            for (int i = 3; i >= 0; i--) if (d[i]) return 2'(i);
        end else begin
            for (int i = 0; i <= 3; i++) if (d[i]) return 2'(i);
        end
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_code[k]  = 2'b00;
            m_valid[k] = 1'b0;
            m_multi[k] = 1'b0;
            m_chg[k]   = 1'b0;
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] d);
        cur_en = en;
        cur_d  = d;
        bus_lo.en = en; bus_lo.d0 = d[0]; bus_lo.d1 = d[1]; bus_lo.d2 = d[2]; bus_lo.d3 = d[3];
        bus_hi.en = en; bus_hi.d0 = d[0]; bus_hi.d1 = d[1]; bus_hi.d2 = d[2]; bus_hi.d3 = d[3];
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_lo_ab"},    {bus_lo.a, bus_lo.b}, m_code[0]);
        check({tag, "_lo_valid"}, 2'(bus_lo.valid),     2'(m_valid[0]));
        check({tag, "_lo_multi"}, 2'(bus_lo.multi),     2'(m_multi[0]));
        check({tag, "_lo_chg"},   2'(bus_lo.chg),       2'(m_chg[0]));
        check({tag, "_hi_ab"},    {bus_hi.a, bus_hi.b}, m_code[1]);
        check({tag, "_hi_valid"}, 2'(bus_hi.valid),     2'(m_valid[1]));
        check({tag, "_hi_multi"}, 2'(bus_hi.multi),     2'(m_multi[1]));
        check({tag, "_hi_chg"},   2'(bus_hi.chg),       2'(m_chg[1]));
    endtask

    // Advance model and DUT by one rising edge, then compare.
    task automatic tick(input string tag);
        logic [1:0] nc;
        for (int k = 0; k < 2; k++) begin
            if (cur_en) begin
                nc         = winner(cur_d, (k == 1));
                m_chg[k]   = (nc != m_code[k]);
                m_code[k]  = nc;
                m_valid[k] = (cur_d != 4'b0000);
                m_multi[k] = ($countones(cur_d) >= 2);
            end else begin
                m_chg[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [3:0] dv;
        logic [3:0] sweep [4];
        sweep[0] = 4'b0001; sweep[1] = 4'b0010; sweep[2] = 4'b0100; sweep[3] = 4'b1000;

        // Reset with idle requests, then release.
        rst = 1'b1;
        drive(1'b1, 4'b0000);
        model_reset();
        #2;
        check_all("reset");
        #10;
        rst = 1'b0;
        tick("idle_after_reset");

        // One-hot sweep d0..d3.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, sweep[i]);
            tick($sformatf("onehot%0d", i));
        end

        // Multiple requests d3,d1,d0: priority order decides.
        drive(1'b1, 4'b1011);
        tick("multi_1011");
        check("multi_1011_hi_lit", {bus_hi.a, bus_hi.b}, 2'b11);
        check("multi_1011_lo_lit", {bus_lo.a, bus_lo.b}, 2'b00);

        // Free-running toggles with periods 16/12/8/4 cycles on d0..d3.
        for (int t = 0; t < 48; t++) begin
            dv[0] = 1'((t / 8) % 2);
            dv[1] = 1'((t / 6) % 2);
            dv[2] = 1'((t / 4) % 2);
            dv[3] = 1'((t / 2) % 2);
            drive(1'b1, dv);
            tick("toggle");
        end

        // Hold with en=0 while requests change, then resume.
        drive(1'b1, 4'b0001);
        tick("hold_setup");
        drive(1'b0, 4'b1000);
        tick("hold_en0");
        tick("hold_en0_b");
        drive(1'b1, 4'b1000);
        tick("hold_resume");
        check("hold_resume_chg_lit", 2'(bus_hi.chg), 2'b01);

        // Random requests and enable.
        for (int t = 0; t < 80; t++) begin
            drive(($urandom_range(3) != 0), 4'($urandom));
            tick("random");
        end

        // Asynchronous reset between edges while code is 11.
        drive(1'b1, 4'b1000);
        tick("pre_async");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        #1;
        check_all("async_reset_hold");
        @(posedge clk);
        #1;
        check_all("async_reset_edge");
        #2;
        rst = 1'b0;
        drive(1'b1, 4'b0100);
        tick("after_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
